// File: rtl/lamp_grid_ctrl.sv
// Single-lamp cursor on a COLS x ROWS grid, stepped by edge-detected direction buttons.
// Optional hold-to-repeat behaviour is built only when LAMP_GRID_AUTOREPEAT_EN is defined.
module lamp_grid_ctrl #(
  parameter int COLS       = 4,
  parameter int ROWS       = 4,
  parameter int WRAP       = 0,
  parameter int REPEAT_DLY = 8,
  parameter int REPEAT_PER = 4,
  localparam int CW = ($clog2(COLS) < 1) ? 1 : $clog2(COLS),
  localparam int RW = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS),
  localparam int N  = COLS * ROWS
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [N-1:0]  lamp,
  output logic          moved,
  output logic          blocked
);

  if (COLS < 2 || ROWS < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cfg
    $error("lamp_grid_ctrl: illegal parameter set");
  end

  logic [3:0]    btn_s;
  logic [3:0]    btn_q_r;
  logic          live_r;
  logic [3:0]    press_s;
  logic          req_s;
  logic [1:0]    dir_s;
  logic          edge_s;
  logic [CW-1:0] col_n_s;
  logic [RW-1:0] row_n_s;
  logic [N-1:0]  lamp_n_s;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [N-1:0]  lamp_r;
  logic          moved_r;
  logic          blocked_r;

  // dir encoding follows btn_s bit positions: 3=up, 2=down, 1=left, 0=right
  assign btn_s = {up, down, left, right};

  // live_r masks the first edge after reset so a key held through clr needs a fresh press
  assign press_s = live_r ? (btn_s & ~btn_q_r) : 4'b0000;

`ifdef LAMP_GRID_AUTOREPEAT_EN
  localparam int CMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNTW = ($clog2(CMAX) < 1) ? 1 : $clog2(CMAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_RPT  = 2'd2
  } rpt_state_t;

  rpt_state_t      st_r;
  logic [CNTW-1:0] cnt_r;
  logic [1:0]      trk_r;
  logic            held_s;
  logic            rpt_fire_s;

  assign held_s     = btn_s[trk_r];
  assign rpt_fire_s = held_s &&
                      (((st_r == S_HELD) && (cnt_r == CNTW'(REPEAT_DLY - 1))) ||
                       ((st_r == S_RPT)  && (cnt_r == CNTW'(REPEAT_PER - 1))));
`endif

  // Pick at most one move per cycle: fresh press by priority, else a due repeat
  always_comb begin
    req_s = 1'b0;
    dir_s = 2'd0;
    if (en) begin
      if (press_s[3]) begin
        req_s = 1'b1;
        dir_s = 2'd3;
      end else if (press_s[2]) begin
        req_s = 1'b1;
        dir_s = 2'd2;
      end else if (press_s[1]) begin
        req_s = 1'b1;
        dir_s = 2'd1;
      end else if (press_s[0]) begin
        req_s = 1'b1;
        dir_s = 2'd0;
`ifdef LAMP_GRID_AUTOREPEAT_EN
      end else if (rpt_fire_s) begin
        req_s = 1'b1;
        dir_s = trk_r;
`endif
      end else begin
        req_s = 1'b0;
      end
    end else begin
      req_s = 1'b0;
    end
  end

  // Target cell for the selected move, with clamp or wrap at the grid border
  always_comb begin
    col_n_s = col_r;
    row_n_s = row_r;
    edge_s  = 1'b0;
    if (req_s) begin
      case (dir_s)
        2'd3: begin
          if (row_r == RW'(0)) begin
            if (WRAP != 0) row_n_s = RW'(ROWS - 1);
            else           edge_s  = 1'b1;
          end else begin
            row_n_s = row_r - RW'(1);
          end
        end
        2'd2: begin
          if (row_r == RW'(ROWS - 1)) begin
            if (WRAP != 0) row_n_s = RW'(0);
            else           edge_s  = 1'b1;
          end else begin
            row_n_s = row_r + RW'(1);
          end
        end
        2'd1: begin
          if (col_r == CW'(0)) begin
            if (WRAP != 0) col_n_s = CW'(COLS - 1);
            else           edge_s  = 1'b1;
          end else begin
            col_n_s = col_r - CW'(1);
          end
        end
        2'd0: begin
          if (col_r == CW'(COLS - 1)) begin
            if (WRAP != 0) col_n_s = CW'(0);
            else           edge_s  = 1'b1;
          end else begin
            col_n_s = col_r + CW'(1);
          end
        end
        default: begin
          edge_s = 1'b0;
        end
      endcase
    end else begin
      edge_s = 1'b0;
    end
  end

  // One-hot decode of the target cell
  always_comb begin
    lamp_n_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        lamp_n_s[r*COLS + c] = (row_n_s == RW'(r)) && (col_n_s == CW'(c));
      end
    end
  end

  // Button history, position, lamp and status pulses
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      btn_q_r   <= 4'b0000;
      live_r    <= 1'b0;
      col_r     <= '0;
      row_r     <= '0;
      lamp_r    <= N'(1);
      moved_r   <= 1'b0;
      blocked_r <= 1'b0;
    end else begin
      btn_q_r <= btn_s;
      live_r  <= 1'b1;
      if (en) begin
        col_r     <= col_n_s;
        row_r     <= row_n_s;
        lamp_r    <= lamp_n_s;
        moved_r   <= req_s & ~edge_s;
        blocked_r <= req_s & edge_s;
      end else begin
        moved_r   <= 1'b0;
        blocked_r <= 1'b0;
      end
    end
  end

`ifdef LAMP_GRID_AUTOREPEAT_EN
  // Repeat FSM: any fresh press re-arms the delay and retargets the tracked key
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_r  <= S_IDLE;
      cnt_r <= '0;
      trk_r <= 2'd0;
    end else if (!en) begin
      cnt_r <= '0;
    end else if (|press_s) begin
      st_r  <= S_HELD;
      cnt_r <= '0;
      trk_r <= dir_s;
    end else begin
      case (st_r)
        S_IDLE: begin
          cnt_r <= '0;
        end
        S_HELD: begin
          if (!held_s) begin
            st_r  <= S_IDLE;
            cnt_r <= '0;
          end else if (cnt_r == CNTW'(REPEAT_DLY - 1)) begin
            st_r  <= S_RPT;
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNTW'(1);
          end
        end
        S_RPT: begin
          if (!held_s) begin
            st_r  <= S_IDLE;
            cnt_r <= '0;
          end else if (cnt_r == CNTW'(REPEAT_PER - 1)) begin
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNTW'(1);
          end
        end
        default: begin
          st_r  <= S_IDLE;
          cnt_r <= '0;
        end
      endcase
    end
  end
`endif

  assign col     = col_r;
  assign row     = row_r;
  assign lamp    = lamp_r;
  assign moved   = moved_r;
  assign blocked = blocked_r;

endmodule
